// File: rtl/input_mat_load_ctrl.sv
// Input-matrix bank sequencer: row-major LOAD of an NxN byte stream into the bank,
// then a diagonally skewed FEED read schedule toward the systolic array.
//   state | meaning
//   IDLE  | waiting for start_load
//   LOAD  | accepting elements, one bank write per handshake
//   FULL  | matrix held, waiting for feed_start
//   FEED  | streaming skewed schedule, t = 0 .. 2N-2
//   DONE  | one-cycle completion pulse
module input_mat_load_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int BANK_DEPTH = 8,
  parameter int IDX_W      = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_load,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        in_ready,
  output logic                        wr_en,
  output logic [IDX_W-1:0]            wr_row,
  output logic [IDX_W-1:0]            wr_col,
  output logic [DATA_WIDTH-1:0]       wr_data,
  output logic                        mat_loaded,
  input  logic                        feed_start,
  output logic [BANK_DEPTH-1:0]       feed_row_valid,
  output logic [BANK_DEPTH*IDX_W-1:0] feed_col_idx,
  output logic                        feed_busy,
  output logic                        done
);

  localparam int KW = 2 * IDX_W;
  localparam int TW = IDX_W + 1;
  localparam logic [KW-1:0] K_LAST = KW'(BANK_DEPTH * BANK_DEPTH - 1);
  localparam logic [TW-1:0] T_LAST = TW'(2 * BANK_DEPTH - 2);

  typedef enum logic [2:0] {IDLE, LOAD, FULL, FEED, DONE} state_t;

  state_t                      state_q, state_d;
  logic [KW-1:0]               k_q, k_d;
  logic [TW-1:0]               t_q, t_d;
  logic                        in_ready_q, in_ready_d;
  logic                        wr_en_q, wr_en_d;
  logic [IDX_W-1:0]            wr_row_q, wr_row_d;
  logic [IDX_W-1:0]            wr_col_q, wr_col_d;
  logic [DATA_WIDTH-1:0]       wr_data_q, wr_data_d;
  logic                        mat_loaded_q, mat_loaded_d;
  logic                        feed_busy_q, feed_busy_d;
  logic                        done_q, done_d;
  logic [BANK_DEPTH-1:0]       frv_q, frv_d;
  logic [BANK_DEPTH*IDX_W-1:0] fci_q, fci_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      k_q          <= '0;
      t_q          <= '0;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      wr_data_q    <= '0;
      mat_loaded_q <= 1'b0;
      feed_busy_q  <= 1'b0;
      done_q       <= 1'b0;
      frv_q        <= '0;
      fci_q        <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      t_q          <= t_d;
      in_ready_q   <= in_ready_d;
      wr_en_q      <= wr_en_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      wr_data_q    <= wr_data_d;
      mat_loaded_q <= mat_loaded_d;
      feed_busy_q  <= feed_busy_d;
      done_q       <= done_d;
      frv_q        <= frv_d;
      fci_q        <= fci_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    t_d          = t_q;
    in_ready_d   = in_ready_q;
    wr_en_d      = 1'b0;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    wr_data_d    = wr_data_q;
    mat_loaded_d = mat_loaded_q;
    feed_busy_d  = 1'b0;
    done_d       = 1'b0;
    frv_d        = '0;
    fci_d        = '0;

    unique case (state_q)
      IDLE: begin
        if (start_load) begin
          state_d    = LOAD;
          k_d        = '0;
          in_ready_d = 1'b1;
        end
      end
      LOAD: begin
        if (in_valid && in_ready_q) begin
          wr_en_d   = 1'b1;
          wr_row_d  = k_q[KW-1:IDX_W];
          wr_col_d  = k_q[IDX_W-1:0];
          wr_data_d = in_data;
          // Final element: k holds at N*N-1 rather than wrapping.
          if (k_q == K_LAST) begin
            state_d      = FULL;
            in_ready_d   = 1'b0;
            mat_loaded_d = 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (feed_start) begin
          state_d     = FEED;
          t_d         = '0;
          feed_busy_d = 1'b1;
        end
      end
      FEED: begin
        if (t_q == T_LAST) begin
          state_d      = DONE;
          done_d       = 1'b1;
          mat_loaded_d = 1'b0;
        end else begin
          t_d         = t_q + 1'b1;
          feed_busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered schedule for the step about to be presented: row r is live for t in [r, r+N-1].
    if (feed_busy_d) begin
      for (int r = 0; r < BANK_DEPTH; r++) begin
        if ((int'(t_d) >= r) && (int'(t_d) <= r + BANK_DEPTH - 1)) begin
          frv_d[r]                  = 1'b1;
          fci_d[r*IDX_W +: IDX_W] = IDX_W'(int'(t_d) - r);
        end
      end
    end
  end

  assign in_ready       = in_ready_q;
  assign wr_en          = wr_en_q;
  assign wr_row         = wr_row_q;
  assign wr_col         = wr_col_q;
  assign wr_data        = wr_data_q;
  assign mat_loaded     = mat_loaded_q;
  assign feed_busy      = feed_busy_q;
  assign done           = done_q;
  assign feed_row_valid = frv_q;
  assign feed_col_idx   = fci_q;

endmodule

// File: tb/tb_input_mat_load_ctrl.sv
// Directed bench for input_mat_load_ctrl: loads, skewed feed schedule, ignored requests,
// and asynchronous reset during LOAD and FEED.
module tb_input_mat_load_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_load;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [2:0]  wr_row;
  logic [2:0]  wr_col;
  logic [7:0]  wr_data;
  logic        mat_loaded;
  logic        feed_start;
  logic [7:0]  feed_row_valid;
  logic [23:0] feed_col_idx;
  logic        feed_busy;
  logic        done;

  int vec_cnt = 0;
  int err_cnt = 0;

  input_mat_load_ctrl #(.DATA_WIDTH(8), .BANK_DEPTH(8), .IDX_W(3)) dut (
    .clk(clk), .reset(reset), .start_load(start_load), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .mat_loaded(mat_loaded),
    .feed_start(feed_start), .feed_row_valid(feed_row_valid),
    .feed_col_idx(feed_col_idx), .feed_busy(feed_busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vec_cnt);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1; start_load = 1'b0; in_valid = 1'b0; in_data = 8'h00; feed_start = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({in_ready, wr_en, mat_loaded, feed_busy, done} !== 5'b0) begin
      err_cnt++; $display("FAIL reset_flags: got %b want 00000", {in_ready, wr_en, mat_loaded, feed_busy, done});
    end
    vec_cnt++;
    if ({wr_row, wr_col, wr_data} !== 14'h0) begin
      err_cnt++; $display("FAIL reset_wr_bus: got %h want 0", {wr_row, wr_col, wr_data});
    end
    vec_cnt++;
    if ({feed_row_valid, feed_col_idx} !== 32'h0) begin
      err_cnt++; $display("FAIL reset_feed_bus: got %h want 0", {feed_row_valid, feed_col_idx});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // In IDLE: feed_start and in_valid must both be ignored.
  task automatic test_idle_ignored();
    feed_start = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    feed_start = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    vec_cnt++;
    if ({feed_busy, in_ready, wr_en, done} !== 4'b0) begin
      err_cnt++; $display("FAIL idle_ignored: busy/ready/wr_en/done got %b want 0000", {feed_busy, in_ready, wr_en, done});
    end
  endtask

  task automatic do_start_load();
    @(negedge clk);
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    vec_cnt++;
    if (in_ready !== 1'b1 || wr_en !== 1'b0) begin
      err_cnt++; $display("FAIL load_entry: in_ready=%b wr_en=%b want 1/0", in_ready, wr_en);
    end
  endtask

  task automatic test_load_b2b();
    do_start_load();
    for (int c = 0; c <= 64; c++) begin
      if (c > 0) begin
        vec_cnt++;
        if (wr_en !== 1'b1 || wr_row !== 3'((c-1)/8) || wr_col !== 3'((c-1)%8) || wr_data !== 8'(c-1)) begin
          err_cnt++;
          $display("FAIL b2b_write[%0d]: got en=%b row=%0d col=%0d data=%h want 1 %0d %0d %h",
                   c-1, wr_en, wr_row, wr_col, wr_data, (c-1)/8, (c-1)%8, 8'(c-1));
        end
        vec_cnt++;
        if (c < 64 && (in_ready !== 1'b1 || mat_loaded !== 1'b0)) begin
          err_cnt++; $display("FAIL b2b_ready[%0d]: in_ready=%b mat_loaded=%b want 1/0", c-1, in_ready, mat_loaded);
        end else if (c == 64 && (in_ready !== 1'b0 || mat_loaded !== 1'b1)) begin
          err_cnt++; $display("FAIL b2b_last: in_ready=%b mat_loaded=%b want 0/1", in_ready, mat_loaded);
        end
      end
      if (c < 64) begin
        in_valid = 1'b1; in_data = 8'(c);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    vec_cnt++;
    if (wr_en !== 1'b0 || mat_loaded !== 1'b1) begin
      err_cnt++; $display("FAIL b2b_after: wr_en=%b mat_loaded=%b want 0/1", wr_en, mat_loaded);
    end
  endtask

  // Alternating in_valid, with a stray feed_start pulse in the middle of LOAD.
  task automatic test_load_gaps();
    int widx;
    widx = 0;
    do_start_load();
    for (int c = 0; c <= 128; c++) begin
      if (c > 0) begin
        vec_cnt++;
        if (wr_en !== (((c-1) % 2) == 0)) begin
          err_cnt++; $display("FAIL gap_wr_en[cycle %0d]: got %b want %b", c, wr_en, ((c-1) % 2) == 0);
        end
        if (wr_en === 1'b1) begin
          vec_cnt++;
          if (wr_row !== 3'(widx/8) || wr_col !== 3'(widx%8) || wr_data !== 8'(widx)) begin
            err_cnt++;
            $display("FAIL gap_write[%0d]: got row=%0d col=%0d data=%h want %0d %0d %h",
                     widx, wr_row, wr_col, wr_data, widx/8, widx%8, 8'(widx));
          end
          widx++;
        end
      end
      if (c < 128) begin
        in_valid = ((c % 2) == 0); in_data = 8'(c/2);
      end else begin
        in_valid = 1'b0;
      end
      feed_start = (c == 11);
      @(negedge clk);
    end
    vec_cnt++;
    if (widx !== 64) begin
      err_cnt++; $display("FAIL gap_count: got %0d writes want 64", widx);
    end
    vec_cnt++;
    if (mat_loaded !== 1'b1 || feed_busy !== 1'b0 || in_ready !== 1'b0) begin
      err_cnt++; $display("FAIL gap_full: mat_loaded=%b feed_busy=%b in_ready=%b want 1/0/0", mat_loaded, feed_busy, in_ready);
    end
  endtask

  task automatic test_feed(input bit inject);
    logic [7:0]  exp_v;
    logic [23:0] exp_i;
    vec_cnt++;
    if (mat_loaded !== 1'b1 || feed_busy !== 1'b0) begin
      err_cnt++; $display("FAIL feed_pre: mat_loaded=%b feed_busy=%b want 1/0", mat_loaded, feed_busy);
    end
    if (inject) begin
      start_load = 1'b1;
      @(negedge clk);
      start_load = 1'b0;
      @(negedge clk);
      vec_cnt++;
      if (in_ready !== 1'b0 || wr_en !== 1'b0 || mat_loaded !== 1'b1) begin
        err_cnt++; $display("FAIL full_ignore_load: in_ready=%b wr_en=%b mat_loaded=%b want 0/0/1", in_ready, wr_en, mat_loaded);
      end
    end
    feed_start = 1'b1;
    for (int t = 0; t <= 14; t++) begin
      @(negedge clk);
      feed_start = 1'b0;
      start_load = inject && (t == 3);
      exp_v = '0; exp_i = '0;
      for (int r = 0; r < 8; r++) begin
        if (t >= r && t <= r + 7) begin
          exp_v[r] = 1'b1;
          exp_i[r*3 +: 3] = 3'(t - r);
        end
      end
      vec_cnt++;
      if (feed_row_valid !== exp_v || feed_col_idx !== exp_i) begin
        err_cnt++; $display("FAIL feed_sched[t=%0d]: got v=%h idx=%h want v=%h idx=%h", t, feed_row_valid, feed_col_idx, exp_v, exp_i);
      end
      vec_cnt++;
      if (feed_busy !== 1'b1 || done !== 1'b0 || mat_loaded !== 1'b1 || wr_en !== 1'b0) begin
        err_cnt++; $display("FAIL feed_flags[t=%0d]: busy=%b done=%b loaded=%b wr_en=%b want 1/0/1/0", t, feed_busy, done, mat_loaded, wr_en);
      end
      if (t == 0) begin
        vec_cnt++;
        if (feed_row_valid !== 8'h01 || feed_col_idx !== 24'h000000) begin
          err_cnt++; $display("FAIL feed_t0: got v=%h idx=%h want 01 000000", feed_row_valid, feed_col_idx);
        end
      end else if (t == 7) begin
        vec_cnt++;
        if (feed_row_valid !== 8'hFF || feed_col_idx !== 24'b000_001_010_011_100_101_110_111) begin
          err_cnt++; $display("FAIL feed_t7: got v=%h idx=%h want ff 053977", feed_row_valid, feed_col_idx);
        end
      end else if (t == 14) begin
        vec_cnt++;
        if (feed_row_valid !== 8'h80 || feed_col_idx !== 24'hE00000) begin
          err_cnt++; $display("FAIL feed_t14: got v=%h idx=%h want 80 e00000", feed_row_valid, feed_col_idx);
        end
      end
    end
    start_load = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (done !== 1'b1 || feed_busy !== 1'b0 || mat_loaded !== 1'b0 || feed_row_valid !== 8'h00) begin
      err_cnt++; $display("FAIL feed_done: done=%b busy=%b loaded=%b v=%h want 1/0/0/00", done, feed_busy, mat_loaded, feed_row_valid);
    end
    @(negedge clk);
    vec_cnt++;
    if (done !== 1'b0 || in_ready !== 1'b0 || feed_busy !== 1'b0) begin
      err_cnt++; $display("FAIL feed_after: done=%b in_ready=%b busy=%b want 0/0/0", done, in_ready, feed_busy);
    end
  endtask

  task automatic test_reset_mid_load();
    do_start_load();
    for (int c = 0; c < 30; c++) begin
      in_valid = 1'b1; in_data = 8'(c);
      @(negedge clk);
    end
    vec_cnt++;
    if (wr_en !== 1'b1 || wr_row !== 3'd3 || wr_col !== 3'd5 || wr_data !== 8'd29) begin
      err_cnt++; $display("FAIL pre_reset_write: en=%b row=%0d col=%0d data=%h want 1 3 5 1d", wr_en, wr_row, wr_col, wr_data);
    end
    #2 reset = 1'b1;
    #1;
    vec_cnt++;
    if ({in_ready, wr_en, mat_loaded, feed_busy, done} !== 5'b0 || {wr_row, wr_col, wr_data} !== 14'h0) begin
      err_cnt++; $display("FAIL async_reset_load: flags=%b wr=%h want 0", {in_ready, wr_en, mat_loaded, feed_busy, done}, {wr_row, wr_col, wr_data});
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (wr_en !== 1'b0 || in_ready !== 1'b0) begin
      err_cnt++; $display("FAIL post_reset_idle: wr_en=%b in_ready=%b want 0/0", wr_en, in_ready);
    end
  endtask

  task automatic test_reset_mid_feed();
    feed_start = 1'b1;
    for (int t = 0; t <= 5; t++) begin
      @(negedge clk);
      feed_start = 1'b0;
    end
    vec_cnt++;
    if (feed_row_valid !== 8'h3F || feed_busy !== 1'b1) begin
      err_cnt++; $display("FAIL feed_t5: v=%h busy=%b want 3f/1", feed_row_valid, feed_busy);
    end
    #2 reset = 1'b1;
    #1;
    vec_cnt++;
    if (feed_row_valid !== 8'h00 || feed_col_idx !== 24'h0 || feed_busy !== 1'b0 || mat_loaded !== 1'b0 || done !== 1'b0) begin
      err_cnt++; $display("FAIL async_reset_feed: v=%h idx=%h busy=%b loaded=%b done=%b want all 0", feed_row_valid, feed_col_idx, feed_busy, mat_loaded, done);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vec_cnt++;
      if (done !== 1'b0 || feed_busy !== 1'b0 || feed_row_valid !== 8'h00) begin
        err_cnt++; $display("FAIL no_done_after_reset[%0d]: done=%b busy=%b v=%h want 0/0/00", c, done, feed_busy, feed_row_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignored();
    test_load_b2b();
    test_feed(1'b0);
    test_load_gaps();
    test_feed(1'b1);
    test_reset_mid_load();
    test_load_b2b();
    test_reset_mid_feed();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/input_mat_load_ctrl.md
Name: input_mat_load_ctrl

Overview:
- Controller that sequences the 8x8 input-matrix register bank used by the systolic array.
- LOAD phase: accepts a byte stream over a valid/ready handshake and generates row-major write commands (row select, column select, write enable, data) for the bank.
- FEED phase: on request from the array, produces the diagonally skewed row/column read schedule, so that row r enters the array r cycles after row 0.

Parameters:
- DATA_WIDTH, 8: element width in bits.
- BANK_DEPTH, 8: matrix dimension N (N rows x N columns).
- IDX_W, 3: index width, equal to log2(BANK_DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_load  input  1  one-cycle request to begin loading a new matrix.
- in_valid  input  1  in_data is valid.
- in_data  input  DATA_WIDTH  matrix element, row-major order.
- in_ready  output  1  controller accepts in_data.
- wr_en  output  1  bank write strobe.
- wr_row  output  IDX_W  bank (row) select.
- wr_col  output  IDX_W  element (column) select within the bank.
- wr_data  output  DATA_WIDTH  data to write.
- mat_loaded  output  1  full matrix is held in the bank.
- feed_start  input  1  one-cycle request from the array to stream the matrix.
- feed_row_valid  output  BANK_DEPTH  bit r set: row r presents an element this cycle.
- feed_col_idx  output  BANK_DEPTH*IDX_W  slice r is the column index read from row r.
- feed_busy  output  1  FEED phase in progress.
- done  output  1  one-cycle pulse at the end of FEED.

Behaviour:
- States: IDLE, LOAD, FULL, FEED, DONE. All outputs are registered.
- Reset (asynchronous, any state): state=IDLE; load counter k=0, feed counter t=0; in_ready, wr_en, mat_loaded, feed_busy and done all 0; wr_row, wr_col, wr_data, feed_row_valid and feed_col_idx all 0. Asserting reset mid-LOAD or mid-FEED abandons the operation with no further writes.
- IDLE: start_load=1 -> LOAD, with k=0 and in_ready=1 from the next cycle. feed_start is ignored.
- LOAD:
  - in_ready=1.
  - A handshake is in_valid & in_ready at a rising edge. Element k is captured and, in the following cycle, wr_en=1, wr_row=k/N, wr_col=k%N, wr_data=the captured byte. Write latency is 1 cycle.
  - wr_en=0 in every cycle not following a handshake. k increments per handshake only; in_valid gaps stall the count.
  - On the handshake for k=N*N-1 (the 64th): next state is FULL, and in_ready drops to 0 in the same cycle the final wr_en is driven.
  - start_load and feed_start are ignored.
- FULL:
  - mat_loaded=1, starting the cycle of the final wr_en.
  - feed_start=1 -> FEED, with t=0 on the next cycle. start_load is ignored, so no reload is possible until DONE.
- FEED:
  - feed_busy=1 and mat_loaded stays 1.
  - For each cycle t=0..2N-2 (15 cycles): feed_row_valid[r]=1 iff r <= t <= r+N-1; feed_col_idx slice r = t-r when valid, else 0. t increments every cycle with no stall.
  - After t=2N-2 -> DONE.
- DONE: done=1 for exactly one cycle; feed_busy=0, mat_loaded=0, feed_row_valid=0 -> IDLE.
- Simultaneous start_load and feed_start: only the request legal in the current state is acted on; the other is dropped, not queued.
- Counters do not wrap: k saturates at the transition to FULL, and t resets on entry to FEED.
- in_valid while in_ready=0 is ignored, and data is not captured.

Test Plan:
- Reset then start_load, then 64 back-to-back bytes 0x00..0x3F -> wr_en high for 64 consecutive cycles, each one cycle after its handshake. The write for byte 0x1B has wr_row=3, wr_col=3, wr_data=0x1B. mat_loaded=1 on the cycle of the last write, and in_ready=0 in that same cycle.
- Same load with in_valid deasserted every other cycle -> exactly 64 writes in 128 cycles, row-major order preserved, no duplicate or skipped indices.
- After FULL, pulse feed_start:
  - feed_busy=1 for 15 cycles.
  - t=0: feed_row_valid=8'h01, slice 0 = 0.
  - t=7: feed_row_valid=8'hFF, slice r = 7-r.
  - t=14: feed_row_valid=8'h80, slice 7 = 7.
  - Then done=1 for one cycle, mat_loaded=0, state IDLE.
- feed_start pulsed in IDLE and during LOAD; start_load pulsed in FULL and FEED -> no state change, no extra writes, and the FEED schedule is unaffected.
- Assert reset asynchronously after the 30th handshake; release, then run a full reload -> all outputs 0 immediately on reset, and the next load restarts at wr_row=0, wr_col=0.
- Assert reset at t=5 of FEED -> feed_row_valid=0, feed_busy=0, no done pulse, mat_loaded=0.
